// File: rtl/bus_arb_id_fifo.sv
// Outstanding-transaction ID FIFO for bus_host_arbiter.
// Circular buffer; depth need not be a power of two.
module bus_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt_q == CntW'(Depth));
    assign empty   = (cnt_q == '0);
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wrap_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = wrap_inc(rptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port between hosts.
// Responses are routed back through an in-order ID FIFO.
module bus_host_arbiter #(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NrHosts-1:0]                      host_req_i,
    output logic [NrHosts-1:0]                      host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i,
    input  logic [NrHosts-1:0]                      host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i,
    output logic [NrHosts-1:0]                      host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o,
    output logic [NrHosts-1:0]                      host_err_o,
    output logic                                    device_req_o,
    input  logic                                    device_gnt_i,
    output logic [AddressWidth-1:0]                 device_addr_o,
    output logic                                    device_we_o,
    output logic [DataWidth/8-1:0]                  device_be_o,
    output logic [DataWidth-1:0]                    device_wdata_o,
    input  logic                                    device_rvalid_i,
    input  logic [DataWidth-1:0]                    device_rdata_i,
    input  logic                                    device_err_i,
    output logic                                    spurious_rsp_o
);

    localparam int unsigned IdW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

    logic [IdW-1:0] ptr_q, ptr_d;
    logic [IdW-1:0] winner;
    logic [IdW-1:0] head;
    logic           found;
    logic           full, empty;
    logic           accept, pop;
    logic           spurious_q, spurious_d;

    // Scan from the priority pointer upward, wrapping at NrHosts.
    always_comb begin
        int unsigned idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            idx = (32'(ptr_q) + i) % NrHosts;
            if (!found && host_req_i[IdW'(idx)]) begin
                found  = 1'b1;
                winner = IdW'(idx);
            end
        end
    end

    // Full blocks the request without looking at rvalid.
    assign device_req_o   = found && !full;
    assign accept         = device_req_o && device_gnt_i;
    assign pop            = device_rvalid_i && !empty;
    assign device_addr_o  = found ? host_addr_i[winner]  : '0;
    assign device_we_o    = found ? host_we_i[winner]    : 1'b0;
    assign device_be_o    = found ? host_be_i[winner]    : '0;
    assign device_wdata_o = found ? host_wdata_i[winner] : '0;
    assign spurious_rsp_o = spurious_q;

    always_comb begin
        for (int i = 0; i < int'(NrHosts); i++) begin
            host_gnt_o[i]    = accept && (winner == IdW'(i));
            host_rvalid_o[i] = pop && (head == IdW'(i));
            host_rdata_o[i]  = device_rdata_i;
            host_err_o[i]    = device_err_i;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (winner == IdW'(NrHosts - 1)) ? '0 : winner + 1'b1;
        end
        spurious_d = spurious_q | (device_rvalid_i & empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            spurious_q <= spurious_d;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (accept),
        .pop    (pop),
        .wdata  (winner),
        .rdata  (head),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed and random checks of bus_host_arbiter against a queue-based model.
module tb_bus_host_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;

    logic                  clk;
    logic                  rst_n;
    logic [N-1:0]          host_req;
    logic [N-1:0]          host_gnt;
    logic [N-1:0][AW-1:0]  host_addr;
    logic [N-1:0]          host_we;
    logic [N-1:0][DW/8-1:0] host_be;
    logic [N-1:0][DW-1:0]  host_wdata;
    logic [N-1:0]          host_rvalid;
    logic [N-1:0][DW-1:0]  host_rdata;
    logic [N-1:0]          host_err;
    logic                  dev_req;
    logic                  dev_gnt;
    logic [AW-1:0]         dev_addr;
    logic                  dev_we;
    logic [DW/8-1:0]       dev_be;
    logic [DW-1:0]         dev_wdata;
    logic                  dev_rvalid;
    logic [DW-1:0]         dev_rdata;
    logic                  dev_err;
    logic                  spurious;

    int errors = 0;
    int checks = 0;

    int q[$];
    int m_ptr;
    bit m_spur;
    logic [N-1:0] m_gnt;

    logic [N-1:0] obs_gnt;
    logic [N-1:0] obs_rv;
    logic         obs_dreq;
    logic [DW-1:0] obs_rdata0;
    logic [DW-1:0] obs_rdata1;

    bus_host_arbiter #(
        .NrHosts        (N),
        .DataWidth      (DW),
        .AddressWidth   (AW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .host_req_i      (host_req),
        .host_gnt_o      (host_gnt),
        .host_addr_i     (host_addr),
        .host_we_i       (host_we),
        .host_be_i       (host_be),
        .host_wdata_i    (host_wdata),
        .host_rvalid_o   (host_rvalid),
        .host_rdata_o    (host_rdata),
        .host_err_o      (host_err),
        .device_req_o    (dev_req),
        .device_gnt_i    (dev_gnt),
        .device_addr_o   (dev_addr),
        .device_we_o     (dev_we),
        .device_be_o     (dev_be),
        .device_wdata_o  (dev_wdata),
        .device_rvalid_i (dev_rvalid),
        .device_rdata_i  (dev_rdata),
        .device_err_i    (dev_err),
        .spurious_rsp_o  (spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ptr  = 0;
        m_spur = 1'b0;
    endtask

    // Inputs are set by the caller; check combinational outputs, then clock.
    task automatic step();
        int  w;
        bit  any, full, dreq, acc, pop;
        logic [N-1:0] e_rv;
        #1;
        any = 1'b0;
        w   = 0;
        for (int k = 0; k < N; k++) begin
            int h;
            h = (m_ptr + k) % N;
            if (!any && host_req[h]) begin
                any = 1'b1;
                w   = h;
            end
        end
        full  = (q.size() == MO);
        dreq  = any && !full;
        acc   = dreq && dev_gnt;
        pop   = dev_rvalid && (q.size() != 0);
        m_gnt = '0;
        e_rv  = '0;
        if (acc) m_gnt[w] = 1'b1;
        if (pop) e_rv[q[0]] = 1'b1;
        obs_gnt    = host_gnt;
        obs_rv     = host_rvalid;
        obs_dreq   = dev_req;
        obs_rdata0 = host_rdata[0];
        obs_rdata1 = host_rdata[1];
        chk("dev_req", 64'(dev_req), 64'(dreq));
        chk("host_gnt", 64'(host_gnt), 64'(m_gnt));
        chk("host_rvalid", 64'(host_rvalid), 64'(e_rv));
        chk("dev_addr", 64'(dev_addr), any ? 64'(host_addr[w]) : 64'd0);
        chk("dev_we", 64'(dev_we), any ? 64'(host_we[w]) : 64'd0);
        chk("dev_be", 64'(dev_be), any ? 64'(host_be[w]) : 64'd0);
        chk("dev_wdata", 64'(dev_wdata), any ? 64'(host_wdata[w]) : 64'd0);
        for (int h = 0; h < N; h++) begin
            chk("host_rdata", 64'(host_rdata[h]), 64'(dev_rdata));
            chk("host_err", 64'(host_err[h]), 64'(dev_err));
        end
        chk("spurious", 64'(spurious), 64'(m_spur));
        @(posedge clk);
        if (dev_rvalid && q.size() == 0) m_spur = 1'b1;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(w);
            m_ptr = (w + 1) % N;
        end
        #1;
    endtask

    task automatic do_reset();
        host_req   = '0;
        dev_rvalid = 1'b0;
        rst_n      = 1'b0;
        #2;
        model_reset();
        chk("rst_gnt", 64'(host_gnt), 64'd0);
        chk("rst_rvalid", 64'(host_rvalid), 64'd0);
        chk("rst_spurious", 64'(spurious), 64'd0);
        chk("rst_dev_req", 64'(dev_req), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_seq [4];
        rst_n      = 1'b1;
        host_req   = '0;
        host_addr  = '0;
        host_we    = '0;
        host_be    = '0;
        host_wdata = '0;
        dev_gnt    = 1'b1;
        dev_rvalid = 1'b0;
        dev_rdata  = '0;
        dev_err    = 1'b0;
        m_gnt      = '0;
        model_reset();
        #3;
        do_reset();

        // Single host read
        host_req[0]  = 1'b1;
        host_addr[0] = 32'h0010_0010;
        host_be[0]   = 4'hf;
        step();
        chk("single_gnt0", 64'(obs_gnt), 64'h1);
        host_req[0] = 1'b0;
        dev_rvalid  = 1'b1;
        dev_rdata   = 32'hDEAD_BEEF;
        step();
        chk("single_rvalid0", 64'(obs_rv), 64'h1);
        chk("single_rdata0", 64'(obs_rdata0), 64'hDEAD_BEEF);
        dev_rvalid = 1'b0;
        step();

        // Contention, responses one cycle behind grants
        do_reset();
        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b10;
        exp_seq[2] = 2'b01;
        exp_seq[3] = 2'b10;
        host_req   = 2'b11;
        host_addr[1] = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            dev_rvalid = (i != 0);
            dev_rdata  = 32'(i);
            step();
            chk("contend_gnt", 64'(obs_gnt), 64'(exp_seq[i]));
            if (i != 0) chk("contend_rv", 64'(obs_rv), 64'(exp_seq[i-1]));
        end
        host_req = '0;
        step();
        chk("contend_rv_last", 64'(obs_rv), 64'(exp_seq[3]));
        dev_rvalid = 1'b0;

        // FIFO full
        do_reset();
        host_req = 2'b11;
        step();
        chk("full_g1", 64'(obs_gnt), 64'h1);
        step();
        chk("full_g2", 64'(obs_gnt), 64'h2);
        dev_rvalid = 1'b1;
        step();
        chk("full_req", 64'(obs_dreq), 64'h0);
        chk("full_nognt", 64'(obs_gnt), 64'h0);
        chk("full_rv", 64'(obs_rv), 64'h1);
        dev_rvalid = 1'b0;
        step();
        chk("full_after", 64'(obs_gnt), 64'h1);
        host_req   = '0;
        dev_rvalid = 1'b1;
        step();
        step();
        dev_rvalid = 1'b0;

        // Device stall
        do_reset();
        host_req = 2'b10;
        dev_gnt  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_nognt", 64'(obs_gnt), 64'h0);
        end
        dev_gnt = 1'b1;
        step();
        chk("stall_gnt1", 64'(obs_gnt), 64'h2);
        host_req = 2'b11;
        step();
        chk("stall_next0", 64'(obs_gnt), 64'h1);
        host_req = '0;

        // Spurious response
        do_reset();
        dev_rvalid = 1'b1;
        step();
        chk("spur_norv", 64'(obs_rv), 64'h0);
        dev_rvalid = 1'b0;
        step();
        chk("spur_set", 64'(spurious), 64'h1);
        step();
        chk("spur_hold", 64'(spurious), 64'h1);
        do_reset();
        chk("spur_clear", 64'(spurious), 64'h0);

        // Reset with one transaction outstanding
        host_req = 2'b01;
        step();
        chk("mid_gnt", 64'(obs_gnt), 64'h1);
        host_req   = '0;
        dev_rvalid = 1'b1;
        rst_n      = 1'b0;
        #2;
        model_reset();
        chk("mid_rv_flushed", 64'(host_rvalid), 64'h0);
        chk("mid_spur_low", 64'(spurious), 64'h0);
        dev_rvalid = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dev_rvalid = 1'b1;
        step();
        chk("mid_norv", 64'(obs_rv), 64'h0);
        dev_rvalid = 1'b0;
        host_req   = 2'b11;
        step();
        chk("mid_spur_set", 64'(spurious), 64'h1);
        chk("mid_ptr0", 64'(obs_gnt), 64'h1);

        // Random traffic
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) do_reset();
            for (int h = 0; h < N; h++) begin
                if (!host_req[h] || m_gnt[h]) begin
                    host_req[h]   = ($urandom_range(0, 2) != 0);
                    host_addr[h]  = $urandom();
                    host_we[h]    = 1'($urandom_range(0, 1));
                    host_be[h]    = 4'($urandom_range(0, 15));
                    host_wdata[h] = $urandom();
                end
            end
            dev_gnt    = ($urandom_range(0, 3) != 0);
            dev_rvalid = 1'($urandom_range(0, 1));
            dev_rdata  = $urandom();
            dev_err    = 1'($urandom_range(0, 1));
            m_gnt      = '0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_host_arbiter.md
Name: bus_host_arbiter

Overview:
- Round-robin arbiter that shares one device port between NrHosts requesters using the Ibex req/gnt/rvalid protocol.
- Typical use: core data port plus a second host (DMA or SEAL trace dumper) sharing the simple-system RAM port A.
- Tracks outstanding transactions in an ID FIFO so each rvalid/rdata/err returns to the host that issued the request.
- Sits between the hosts and the bus/RAM, in the simple-system top.

Parameters:
- NrHosts, 2, number of requesting hosts (2..8).
- DataWidth, 32, data width in bits.
- AddressWidth, 32, address width in bits.
- MaxOutstanding, 2, depth of the outstanding-ID FIFO (1..8).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- host_req_i  in  NrHosts x 1  request per host.
- host_gnt_o  out  NrHosts x 1  grant per host.
- host_addr_i  in  NrHosts x AddressWidth  address per host.
- host_we_i  in  NrHosts x 1  write enable per host.
- host_be_i  in  NrHosts x DataWidth/8  byte enables per host.
- host_wdata_i  in  NrHosts x DataWidth  write data per host.
- host_rvalid_o  out  NrHosts x 1  response valid per host.
- host_rdata_o  out  NrHosts x DataWidth  read data per host.
- host_err_o  out  NrHosts x 1  response error per host.
- device_req_o  out  1  request to the device.
- device_gnt_i  in  1  device accepts the request; tie to 1 for RAM.
- device_addr_o  out  AddressWidth  address to the device.
- device_we_o  out  1  write enable to the device.
- device_be_o  out  DataWidth/8  byte enables to the device.
- device_wdata_o  out  DataWidth  write data to the device.
- device_rvalid_i  in  1  device response valid.
- device_rdata_i  in  DataWidth  device read data.
- device_err_i  in  1  device response error.
- spurious_rsp_o  out  1  sticky flag: rvalid arrived with no transaction outstanding.

Behaviour:
- Reset (async, rst_ni low):
  - priority pointer = 0; FIFO empty; spurious_rsp_o = 0.
  - All host_gnt_o and host_rvalid_o = 0, because they are derived from empty state and device_rvalid_i.
- Arbitration (combinational):
  - Winner = first requesting host scanning from the priority pointer upward, modulo NrHosts.
  - device_req_o = any host_req_i && !fifo_full.
  - addr/we/be/wdata are muxed from the winner; all zero when there is no winner.
- Grant:
  - host_gnt_o[winner] = device_req_o && device_gnt_i, in the same cycle; zero-cycle grant latency.
  - At most one host_gnt_o is high per cycle.
- On an accepted grant (registered):
  - Push the winner ID into the FIFO.
  - Priority pointer = (winner+1) mod NrHosts.
  - Without an accepted grant the pointer holds, including while the device stalls with gnt=0.
- Stall: while device_gnt_i=0 the winner may change between cycles. Hosts hold their req until gnt, so nothing is lost.
- Full:
  - fifo_full blocks device_req_o.
  - No grant is given in the cycle the FIFO is full, even if device_rvalid_i pops that cycle. This is deliberate and keeps the request path free of rvalid.
- Response (combinational routing):
  - When device_rvalid_i=1 and the FIFO is not empty, host_rvalid_o[head] = 1 and the FIFO pops.
  - host_rdata_o and host_err_o of every host are driven with device_rdata_i and device_err_i. Only the host whose rvalid is high may sample them.
- Empty:
  - device_rvalid_i with an empty FIFO: no host_rvalid, no pop.
  - spurious_rsp_o is set and stays 1 until reset.
- Simultaneous push and pop when not full: occupancy unchanged, order preserved.
- Response latency: equal to the device latency; one cycle for ram_2p.
- Reset mid-transaction: outstanding IDs are discarded; later device responses set spurious_rsp_o.
- Widths:
  - ID width = $clog2(NrHosts), minimum 1.
  - FIFO count width = $clog2(MaxOutstanding+1).
  - Pointers wrap modulo MaxOutstanding; the depth need not be a power of two.

Decomposition:
- No shared package; all types are parameter-local.
- One sub-module, bus_arb_id_fifo: parameters Depth and Width; ports push, pop, wdata, rdata, full, empty; asynchronous active-low reset; it forms the registered state together with the priority pointer.
- Winner selection stays inline in bus_host_arbiter.

Test Plan:
- **Single host:** host0 reads 0x100010; device_gnt=1, RAM returns 0xDEADBEEF one cycle later → gnt0 in the request cycle; rvalid0 with rdata 0xDEADBEEF next cycle; rvalid1 stays 0.
- **Contention:** both hosts hold req for 4 cycles after reset → grants alternate 0,1,0,1; each rvalid returns to the issuing host in order.
- **FIFO full:** MaxOutstanding=2 and the device withholds rvalid → two grants issued; third cycle has device_req_o=0 and no gnt. Assert rvalid in that cycle → still no gnt that cycle; gnt follows next cycle.
- **Device stall:** device_gnt=0 for 3 cycles with host1 requesting → no gnt and pointer unchanged. Raise gnt → gnt1; next priority goes to host0.
- **Spurious response:** rvalid with an empty FIFO → no host rvalid; spurious_rsp_o rises next cycle and holds until rst_ni pulses low.
- **Mid-operation reset:** assert rst_ni low with one transaction outstanding → FIFO empty and pointer 0 immediately; the subsequent rvalid sets spurious_rsp_o.
